// File: rtl/acs_scheduler_if.sv
// ---------------------------------------------------------------------------
// acs_scheduler_if
// Bundles every non-clock signal of the ACS scheduler.
//   Symbol input    : sym_valid, sym[1:0], sym_ready
//   Shared ACS port : acs_p0/p1_valid, acs_p0/p1_bmc[1:0], acs_p0/p1_pmc[7:0]
//                     (to ACS); acs_valid, acs_selection, acs_cost[7:0] (from ACS)
//   Survivor output : surv_valid, surv_ready, surv_bits[7:0], best_state[2:0]
//   Debug view      : dbg_state (FSM), dbg_idx (state under service),
//                     dbg_metric (current bank, state i at [8*i +: 8]),
//                     dbg_mvalid (current bank valid flags)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; the sender holds its payload stable while valid is 1 and ready is 0.
// Modports: slave = the scheduler, master = its environment.
// ---------------------------------------------------------------------------
interface acs_scheduler_if;
  logic       sym_valid;
  logic [1:0] sym;
  logic       sym_ready;

  logic       acs_p0_valid;
  logic       acs_p1_valid;
  logic [1:0] acs_p0_bmc;
  logic [1:0] acs_p1_bmc;
  logic [7:0] acs_p0_pmc;
  logic [7:0] acs_p1_pmc;
  logic       acs_selection;
  logic       acs_valid;
  logic [7:0] acs_cost;

  logic       surv_valid;
  logic       surv_ready;
  logic [7:0] surv_bits;
  logic [2:0] best_state;

  logic [1:0]  dbg_state;
  logic [2:0]  dbg_idx;
  logic [63:0] dbg_metric;
  logic [7:0]  dbg_mvalid;

  modport slave (
    input  sym_valid, sym, acs_selection, acs_valid, acs_cost, surv_ready,
    output sym_ready, acs_p0_valid, acs_p1_valid, acs_p0_bmc, acs_p1_bmc,
           acs_p0_pmc, acs_p1_pmc, surv_valid, surv_bits, best_state,
           dbg_state, dbg_idx, dbg_metric, dbg_mvalid
  );

  modport master (
    output sym_valid, sym, acs_selection, acs_valid, acs_cost, surv_ready,
    input  sym_ready, acs_p0_valid, acs_p1_valid, acs_p0_bmc, acs_p1_bmc,
           acs_p0_pmc, acs_p1_pmc, surv_valid, surv_bits, best_state,
           dbg_state, dbg_idx, dbg_metric, dbg_mvalid
  );
endinterface

// File: rtl/acs_scheduler.sv
// ---------------------------------------------------------------------------
// acs_scheduler
// Time-multiplexes one external add-compare-select unit over the 8 states of
// a K=4 hard-decision Viterbi trellis. One received code pair is taken in
// IDLE, the 8 states are serviced one per cycle in RUN, and the survivor word
// plus the best state are offered in EMIT.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : acs_scheduler_if.slave (symbol in, ACS port, survivor out, debug)
// ---------------------------------------------------------------------------
module acs_scheduler (
  input  logic            clk,
  input  logic            rst,
  acs_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_idx;
  logic [1:0] r_sym;
  logic       r_sym_ready;
  logic       r_surv_valid;
  logic [7:0] r_surv_bits;
  logic [2:0] r_best_state;
  logic [7:0] r_best_cost;
  logic       r_best_found;

  logic [7:0] r_cur_metric [8];
  logic [7:0] r_cur_valid;
  logic [7:0] r_nxt_metric [8];
  logic [7:0] r_nxt_valid;

  logic [2:0] w_p0;
  logic [2:0] w_p1;
  logic       w_take_best;
  logic       w_all_high;
  logic [7:0] w_fin_metric [8];
  logic [7:0] w_fin_valid;

  // Hamming distance between the received pair and the pair the encoder
  // emits on branch p -> s, where b is the input bit shifted in.
  function automatic logic [1:0] branch_metric(input logic [1:0] rx,
                                               input logic       b,
                                               input logic [2:0] p);
    logic [3:0] r;
    logic [1:0] e;
    logic [1:0] d;
    r = {b, p};
    e = {^r, ^(r & 4'b1101)};
    d = rx ^ e;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  assign w_p0 = {r_idx[1:0], 1'b0};
  assign w_p1 = {r_idx[1:0], 1'b1};

  // ACS request is purely combinational from the current bank so the
  // answer can be captured on the same edge.
  always_comb begin
    bus.acs_p0_valid = 1'b0;
    bus.acs_p1_valid = 1'b0;
    bus.acs_p0_bmc   = 2'd0;
    bus.acs_p1_bmc   = 2'd0;
    bus.acs_p0_pmc   = 8'd0;
    bus.acs_p1_pmc   = 8'd0;
    if (r_state == S_RUN) begin
      bus.acs_p0_valid = r_cur_valid[w_p0];
      bus.acs_p1_valid = r_cur_valid[w_p1];
      bus.acs_p0_bmc   = branch_metric(r_sym, r_idx[2], w_p0);
      bus.acs_p1_bmc   = branch_metric(r_sym, r_idx[2], w_p1);
      bus.acs_p0_pmc   = r_cur_metric[w_p0];
      bus.acs_p1_pmc   = r_cur_metric[w_p1];
    end
  end

  // Ties keep the earlier (lower) index: only a strictly lower cost wins.
  assign w_take_best = bus.acs_valid &&
                       (!r_best_found || (bus.acs_cost < r_best_cost));

  // Next bank as it will look after this edge (entry r_idx replaced by the
  // ACS answer), normalised when every valid metric has reached 128.
  always_comb begin
    w_all_high  = 1'b1;
    w_fin_valid = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) == r_idx) begin
        w_fin_metric[i] = bus.acs_cost;
        w_fin_valid[i]  = bus.acs_valid;
      end else begin
        w_fin_metric[i] = r_nxt_metric[i];
        w_fin_valid[i]  = r_nxt_valid[i];
      end
      if (w_fin_valid[i] && !w_fin_metric[i][7]) w_all_high = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (w_all_high && w_fin_valid[i]) w_fin_metric[i][7] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= 3'd0;
      r_sym        <= 2'd0;
      r_sym_ready  <= 1'b1;
      r_surv_valid <= 1'b0;
      r_surv_bits  <= 8'd0;
      r_best_state <= 3'd0;
      r_best_cost  <= 8'd0;
      r_best_found <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_cur_metric[i] <= 8'd0;
        r_nxt_metric[i] <= 8'd0;
      end
      r_cur_valid  <= 8'h01;
      r_nxt_valid  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.sym_valid && r_sym_ready) begin
            r_sym        <= bus.sym;
            r_state      <= S_RUN;
            r_idx        <= 3'd0;
            r_sym_ready  <= 1'b0;
            r_best_found <= 1'b0;
            r_best_state <= 3'd0;
            r_best_cost  <= 8'd0;
          end
        end
        S_RUN: begin
          r_nxt_metric[r_idx] <= bus.acs_cost;
          r_nxt_valid[r_idx]  <= bus.acs_valid;
          r_surv_bits[r_idx]  <= bus.acs_valid & bus.acs_selection;
          if (w_take_best) begin
            r_best_found <= 1'b1;
            r_best_state <= r_idx;
            r_best_cost  <= bus.acs_cost;
          end
          if (r_idx == 3'd7) begin
            r_state      <= S_EMIT;
            r_idx        <= 3'd0;
            r_surv_valid <= 1'b1;
            r_cur_metric <= w_fin_metric;
            r_cur_valid  <= w_fin_valid;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        S_EMIT: begin
          if (bus.surv_ready) begin
            r_state      <= S_IDLE;
            r_surv_valid <= 1'b0;
            r_sym_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_surv_valid <= 1'b0;
          r_sym_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.sym_ready  = r_sym_ready;
  assign bus.surv_valid = r_surv_valid;
  assign bus.surv_bits  = r_surv_bits;
  assign bus.best_state = r_best_state;
  assign bus.dbg_state  = r_state;
  assign bus.dbg_idx    = r_idx;
  assign bus.dbg_mvalid = r_cur_valid;

  always_comb begin
    bus.dbg_metric = 64'd0;
    for (int i = 0; i < 8; i++) bus.dbg_metric[i*8 +: 8] = r_cur_metric[i];
  end

endmodule

// File: tb/tb_acs_scheduler.sv
// ---------------------------------------------------------------------------
// tb_acs_scheduler
// Directed bench for acs_scheduler. A behavioural ACS answers the scheduler's
// requests (min of pmc+bmc, ties to predecessor 0), or returns a fixed
// per-state table when ovr_en is set so metrics near 255 and ties can be
// forced directly.
// ---------------------------------------------------------------------------
module tb_acs_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acs_scheduler_if bus ();

  acs_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       ovr_en;
  logic [7:0] ovr_cost [8];
  logic [7:0] ovr_valid;
  logic [7:0] ovr_sel;
  logic [7:0] c0;
  logic [7:0] c1;

  always_comb begin
    c0 = bus.acs_p0_pmc + {6'd0, bus.acs_p0_bmc};
    c1 = bus.acs_p1_pmc + {6'd0, bus.acs_p1_bmc};
    bus.acs_valid     = 1'b0;
    bus.acs_selection = 1'b0;
    bus.acs_cost      = 8'd0;
    if (ovr_en) begin
      bus.acs_valid     = ovr_valid[bus.dbg_idx];
      bus.acs_selection = ovr_sel[bus.dbg_idx];
      bus.acs_cost      = ovr_cost[bus.dbg_idx];
    end else if (bus.acs_p0_valid && bus.acs_p1_valid) begin
      bus.acs_valid     = 1'b1;
      bus.acs_selection = (c1 < c0);
      bus.acs_cost      = (c1 < c0) ? c1 : c0;
    end else if (bus.acs_p1_valid) begin
      bus.acs_valid     = 1'b1;
      bus.acs_selection = 1'b1;
      bus.acs_cost      = c1;
    end else if (bus.acs_p0_valid) begin
      bus.acs_valid     = 1'b1;
      bus.acs_cost      = c0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mbyte(input int i);
    return bus.dbg_metric[i*8 +: 8];
  endfunction

  // Returns one cycle after the accepting edge (RUN, idx 0).
  task automatic send_sym(input logic [1:0] s);
    int k;
    bus.sym       = s;
    bus.sym_valid = 1'b1;
    k = 0;
    while (!bus.sym_ready && k < 20) begin
      tick;
      k++;
    end
    chk("sym_accept", {63'd0, bus.sym_ready}, 64'd1);
    tick;
    bus.sym_valid = 1'b0;
  endtask

  task automatic wait_surv(output int n);
    n = 0;
    while (!bus.surv_valid && n < 20) begin
      tick;
      n++;
    end
  endtask

  task automatic release_surv;
    bus.surv_ready = 1'b1;
    tick;
    bus.surv_ready = 1'b0;
  endtask

  task automatic run_ovr(input string tag, input logic [1:0] s,
                         input logic [63:0] costs, input logic [7:0] vmask,
                         input logic [7:0] sel, input logic [7:0] exp_bits,
                         input logic [2:0] exp_best, input logic [7:0] exp_mv,
                         input logic [63:0] exp_metric);
    int n;
    for (int i = 0; i < 8; i++) ovr_cost[i] = costs[i*8 +: 8];
    ovr_valid = vmask;
    ovr_sel   = sel;
    ovr_en    = 1'b1;
    send_sym(s);
    wait_surv(n);
    chk({tag, "_latency"}, 64'(n), 64'd8);
    chk({tag, "_bits"},    {56'd0, bus.surv_bits}, {56'd0, exp_bits});
    chk({tag, "_best"},    {61'd0, bus.best_state}, {61'd0, exp_best});
    chk({tag, "_mvalid"},  {56'd0, bus.dbg_mvalid}, {56'd0, exp_mv});
    chk({tag, "_metric"},  bus.dbg_metric, exp_metric);
    release_surv;
    ovr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    logic snap;
    logic [7:0] s_bits;
    logic [2:0] s_best;
    logic [7:0] s_mv;
    logic [31:0] s_m;
    int hs[$];
    int d1;
    int d2;

    bus.sym_valid  = 1'b0;
    bus.sym        = 2'd0;
    bus.surv_ready = 1'b0;
    ovr_en    = 1'b0;
    ovr_valid = 8'd0;
    ovr_sel   = 8'd0;
    for (int i = 0; i < 8; i++) ovr_cost[i] = 8'd0;

    // Reset state
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk("rst_state",      {62'd0, bus.dbg_state}, 64'd0);
    chk("rst_sym_ready",  {63'd0, bus.sym_ready}, 64'd1);
    chk("rst_surv_valid", {63'd0, bus.surv_valid}, 64'd0);
    chk("rst_surv_bits",  {56'd0, bus.surv_bits}, 64'd0);
    chk("rst_best",       {61'd0, bus.best_state}, 64'd0);
    chk("rst_mvalid",     {56'd0, bus.dbg_mvalid}, 64'h01);
    chk("rst_metric0",    {56'd0, mbyte(0)}, 64'd0);
    chk("rst_acs_idle",   {45'd0, bus.acs_p0_valid, bus.acs_p1_valid, bus.acs_p0_bmc,
                           bus.acs_p1_bmc, bus.acs_p0_pmc, bus.acs_p1_pmc}, 64'd0);

    // sym=00 from reset; sym changes during RUN must not matter
    send_sym(2'b00);
    bus.sym = 2'b11;
    repeat (4) tick;
    chk("t1_idx",       {61'd0, bus.dbg_idx}, 64'd4);
    chk("t1_p0_valid",  {63'd0, bus.acs_p0_valid}, 64'd1);
    chk("t1_p0_pmc",    {56'd0, bus.acs_p0_pmc}, 64'd0);
    chk("t1_p0_bmc",    {62'd0, bus.acs_p0_bmc}, 64'd2);
    chk("t1_p1_valid",  {63'd0, bus.acs_p1_valid}, 64'd0);
    chk("t1_sym_ready", {63'd0, bus.sym_ready}, 64'd0);
    wait_surv(n);
    chk("t1_latency",   64'(n), 64'd4);
    chk("t1_bits",      {56'd0, bus.surv_bits}, 64'h00);
    chk("t1_best",      {61'd0, bus.best_state}, 64'd0);
    chk("t1_mvalid",    {56'd0, bus.dbg_mvalid}, 64'h11);
    chk("t1_metric0",   {56'd0, mbyte(0)}, 64'd0);
    chk("t1_metric4",   {56'd0, mbyte(4)}, 64'd2);
    chk("t1_acs_idle",  {45'd0, bus.acs_p0_valid, bus.acs_p1_valid, bus.acs_p0_bmc,
                         bus.acs_p1_bmc, bus.acs_p0_pmc, bus.acs_p1_pmc}, 64'd0);

    // EMIT held with surv_ready low
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("t2_surv_valid", {63'd0, bus.surv_valid}, 64'd1);
      chk("t2_bits_best",  {53'd0, bus.surv_bits, bus.best_state}, 64'd0);
      chk("t2_sym_ready",  {63'd0, bus.sym_ready}, 64'd0);
    end
    release_surv;
    chk("t2_rel_surv_valid", {63'd0, bus.surv_valid}, 64'd0);
    chk("t2_rel_sym_ready",  {63'd0, bus.sym_ready}, 64'd1);
    chk("t2_rel_state",      {62'd0, bus.dbg_state}, 64'd0);

    // All valid metrics >= 128: bit 7 cleared on valid entries only
    run_ovr("t3_norm", 2'b10, 64'hC8BEFAAAA0968C82, 8'hDF, 8'hAA,
            8'h8A, 3'd0, 8'hDF, 64'h483EFA2A20160C02);
    // Tie between states 3 and 4, lower invalid cost in state 1 ignored
    run_ovr("t4_tie", 2'b01, 64'h50463C14141E0532, 8'hFD, 8'hFF,
            8'hFD, 3'd3, 8'hFD, 64'h50463C14141E0532);
    // One valid metric below 128: no normalisation
    run_ovr("t5_nonorm", 2'b00, 64'hC8C8C8C8C864C8C8, 8'hFF, 8'h0F,
            8'h0F, 3'd2, 8'hFF, 64'hC8C8C8C8C864C8C8);
    // No valid state: survivor bits 0, best 0, invalid metrics untouched
    run_ovr("t6_none", 2'b11, 64'hF0F0F0F0F0F0F0F0, 8'h00, 8'hFF,
            8'h00, 3'd0, 8'h00, 64'hF0F0F0F0F0F0F0F0);

    // Reset in the middle of RUN
    send_sym(2'b01);
    repeat (4) tick;
    chk("t7_idx", {61'd0, bus.dbg_idx}, 64'd4);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t7_state",     {62'd0, bus.dbg_state}, 64'd0);
    chk("t7_sym_ready", {63'd0, bus.sym_ready}, 64'd1);
    chk("t7_mvalid",    {56'd0, bus.dbg_mvalid}, 64'h01);
    seen = bus.surv_valid;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (bus.surv_valid) seen = 1'b1;
    end
    chk("t7_no_surv", {63'd0, seen}, 64'd0);
    send_sym(2'b00);
    wait_surv(n);
    chk("t7_latency", 64'(n), 64'd8);
    chk("t7_bits",    {56'd0, bus.surv_bits}, 64'h00);
    chk("t7_best",    {61'd0, bus.best_state}, 64'd0);
    chk("t7_mvalid",  {56'd0, bus.dbg_mvalid}, 64'h11);
    chk("t7_metric",  {48'd0, mbyte(4), mbyte(0)}, 64'h0200);
    release_surv;

    // Back-to-back symbols with surv_ready held high
    bus.surv_ready = 1'b1;
    bus.sym_valid  = 1'b1;
    snap = 1'b0;
    s_bits = 8'd0;
    s_best = 3'd0;
    s_mv   = 8'd0;
    s_m    = 32'd0;
    for (int k = 0; k < 32; k++) begin
      if (bus.sym_ready) hs.push_back(cyc);
      if (bus.surv_valid && !snap) begin
        snap   = 1'b1;
        s_bits = bus.surv_bits;
        s_best = bus.best_state;
        s_mv   = bus.dbg_mvalid;
        s_m    = {mbyte(6), mbyte(4), mbyte(2), mbyte(0)};
      end
      bus.sym = bus.sym_ready ? 2'b00 : 2'b11;
      tick;
    end
    bus.sym_valid  = 1'b0;
    bus.surv_ready = 1'b0;
    d1 = (hs.size() >= 2) ? hs[1] - hs[0] : -1;
    d2 = (hs.size() >= 3) ? hs[2] - hs[1] : -1;
    chk("t8_accepts", 64'(hs.size()), 64'd4);
    chk("t8_gap1",    64'(d1), 64'd10);
    chk("t8_gap2",    64'(d2), 64'd10);
    chk("t8_snap",    {63'd0, snap}, 64'd1);
    chk("t8_bits",    {56'd0, s_bits}, 64'h00);
    chk("t8_best",    {61'd0, s_best}, 64'd0);
    chk("t8_mvalid",  {56'd0, s_mv}, 64'h55);
    chk("t8_metric",  {32'd0, s_m}, 64'h02020400);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/acs_scheduler.md
ACS_SCHEDULER -- requirements
Module: acs_scheduler

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 sym_valid  input  1  received symbol offered.
REQ-004 sym  input  2  received code pair (hard decision).
REQ-005 sym_ready  output  1  symbol accepted when sym_valid & sym_ready.
REQ-006 acs_p0_valid, acs_p1_valid  output  1 each  predecessor-metric valid flags to shared ACS.
REQ-007 acs_p0_bmc, acs_p1_bmc  output  2 each  branch metrics to ACS.
REQ-008 acs_p0_pmc, acs_p1_pmc  output  8 each  predecessor path metrics to ACS.
REQ-009 acs_selection, acs_valid  input  1 each  ACS decision and result-valid.
REQ-010 acs_cost  input  8  ACS selected path cost.
REQ-011 surv_valid  output  1  survivor word available.
REQ-012 surv_ready  input  1  consumer takes word when surv_valid & surv_ready.
REQ-013 surv_bits  output  8  bit s = ACS selection for state s.
REQ-014 best_state  output  3  lowest-metric valid state of current symbol.

Function
REQ-015 Trellis: 8 states, K=4; predecessors of s: p0={s[1:0],0}, p1={s[1:0],1}; input bit b=s[2].
REQ-016 Expected pair for branch p->s: r={b,p[2:0]}, exp={^(r&4'b1111), ^(r&4'b1101)}; bmc=popcount(sym_reg^exp), range 0..2.
REQ-017 Metric storage: current bank 8x(8-bit metric + valid), next bank same; one shared ACS instance serviced one state per cycle.
REQ-018 FSM states IDLE, RUN, EMIT; IDLE->RUN on symbol handshake; RUN->EMIT after idx 7; EMIT->IDLE on surv handshake.
REQ-019 sym_ready=1 only in IDLE; sym registered into sym_reg on handshake.
REQ-020 RUN: idx counts 0..7, one per cycle; ACS ports driven combinationally from current bank for state idx; acs_valid, acs_cost, acs_selection captured into next bank[idx] and surv_bits[idx] same edge.
REQ-021 ACS ports outside RUN: all valids 0, bmc 0, pmc 0.
REQ-022 best_state tracked incrementally during RUN: strictly-lower valid cost replaces; ties keep lower index; if no valid state, 0.
REQ-023 On RUN->EMIT edge: next bank copied to current bank; if every valid metric has bit7=1, bit7 cleared on all valid metrics (normalisation); invalid entries unchanged.
REQ-024 Latency: symbol accepted cycle T -> RUN T+1..T+8 -> surv_valid=1 from T+9; with surv_ready=1, IDLE at T+10, next symbol at T+10 earliest.
REQ-025 EMIT: surv_valid=1, surv_bits and best_state held stable until handshake; surv_ready while not surv_valid ignored.
REQ-026 surv_bits bits for states with acs_valid=0 are 0.

Reset
REQ-027 rst: state IDLE, idx 0, sym_reg 0, sym_ready 1 next cycle, surv_valid 0, surv_bits 0, best_state 0.
REQ-028 rst: current bank state 0 metric 0 valid; states 1..7 metric 0 invalid; next bank all invalid.
REQ-029 rst in RUN or EMIT: in-flight symbol discarded, no survivor word emitted, reset values apply next cycle.

Verification
REQ-030 Reset, sym=00 -> after 8 RUN cycles surv_valid=1, surv_bits=8'h00, best_state=0; state0 metric 0, state4 metric 2, others invalid.
REQ-031 Hold surv_ready=0 for 5 cycles in EMIT -> surv_valid, surv_bits, best_state unchanged, sym_ready=0; release -> IDLE next cycle.
REQ-032 Back-to-back symbols, surv_ready=1, sym_valid=1 -> one accept every 10 cycles; sym changes while sym_ready=0 have no effect.
REQ-033 Preload all valid metrics >=128 (via stream of sym=11 after reset) -> after swap all metrics <128, relative differences preserved.
REQ-034 Assert rst at RUN idx 4 -> no surv_valid pulse; bank reinit; next sym=00 reproduces REQ-030 result.
REQ-035 Equal-cost tie in two states -> best_state is lower index.
